// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM demultiplexer with frame_sync hunting and realignment
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] sh0_q, sh0_d;
    logic [W-1:0] sh1_q, sh1_d;
    logic [W-1:0] sh2_q, sh2_d;
    logic [W-1:0] y0_q, y0_d;
    logic [W-1:0] y1_q, y1_d;
    logic [W-1:0] y2_q, y2_d;
    logic [W-1:0] y3_q, y3_d;
    logic         fv_q, fv_d;
    logic         se_q, se_d;

    // State, shadow and output registers; reset clears everything without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    // Framing FSM: idle cycles hold everything, only the pulses fall back to 0
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        sh0_d   = din;
                        slot_d  = 2'd1;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Sync on slot 0 is the normal frame start; anywhere else it realigns
                        se_d   = (slot_q != 2'd0);
                        sh0_d  = din;
                        slot_d = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end else if (slot_q == 2'd3) begin
                        // Whole frame moves to Y at once so no partial frame is ever visible
                        y0_d   = sh0_q;
                        y1_d   = sh1_q;
                        y2_d   = sh2_q;
                        y3_d   = din;
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
                    end else begin
                        case (slot_q)
                            2'd1:    sh1_d = din;
                            2'd2:    sh2_d = din;
                            default: sh0_d = sh0_q;
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign Y0          = y0_q;
    assign Y1          = y1_q;
    assign Y2          = y2_q;
    assign Y3          = y3_q;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed scoreboard bench for tdm_demux4
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] Y0, Y1, Y2, Y3;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_frame = 32'h0;

    tdm_demux4 #(.W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .frame_sync(frame_sync),
        .Y0(Y0),
        .Y1(Y1),
        .Y2(Y2),
        .Y3(Y3),
        .frame_valid(frame_valid),
        .slot(slot),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        sb_q.push_back({a, b, c, d});
    endtask

    // Drive one cycle, then check status outputs and Y against the scoreboard
    task automatic step(input logic [7:0] d, input logic v, input logic fs,
                        input logic [1:0] e_slot, input logic e_lk, input logic e_fv, input logic e_se);
        @(negedge clk);
        din        = d;
        din_valid  = v;
        frame_sync = fs;
        @(posedge clk);
        #1;
        chk("slot", 32'(slot), 32'(e_slot));
        chk("locked", 32'(locked), 32'(e_lk));
        chk("frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("sync_err", 32'(sync_err), 32'(e_se));
        if (frame_valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) last_frame = sb_q.pop_front();
        end
        chk("Y", {Y0, Y1, Y2, Y3}, last_frame);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_Y"}, {Y0, Y1, Y2, Y3}, 32'h0);
        chk({tag, "_status"}, {27'h0, frame_valid, sync_err, slot, locked}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #23;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame A1..D4 then idle: pulse lasts one cycle, Y holds
        step(8'hA1, 1, 1, 2'd1, 1, 0, 0);
        step(8'hB2, 1, 0, 2'd2, 1, 0, 0);
        step(8'hC3, 1, 0, 2'd3, 1, 0, 0);
        push(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        step(8'hD4, 1, 0, 2'd0, 1, 1, 0);
        step(8'h00, 0, 0, 2'd0, 1, 0, 0);

        // Missing sync after a completed frame drops to HUNT
        step(8'h77, 1, 0, 2'd0, 0, 0, 1);

        // Unsynced words discarded in HUNT, then a synced frame
        step(8'h11, 1, 0, 2'd0, 0, 0, 0);
        step(8'h22, 1, 0, 2'd0, 0, 0, 0);
        step(8'h01, 1, 1, 2'd1, 1, 0, 0);
        step(8'h02, 1, 0, 2'd2, 1, 0, 0);
        step(8'h03, 1, 0, 2'd3, 1, 0, 0);
        push(8'h01, 8'h02, 8'h03, 8'h04);
        step(8'h04, 1, 0, 2'd0, 1, 1, 0);

        // Back-to-back frame, no idle cycle
        step(8'h05, 1, 1, 2'd1, 1, 0, 0);
        step(8'h06, 1, 0, 2'd2, 1, 0, 0);
        step(8'h07, 1, 0, 2'd3, 1, 0, 0);
        push(8'h05, 8'h06, 8'h07, 8'h08);
        step(8'h08, 1, 0, 2'd0, 1, 1, 0);

        // Realign on early sync at slot 2
        step(8'h10, 1, 1, 2'd1, 1, 0, 0);
        step(8'h20, 1, 0, 2'd2, 1, 0, 0);
        step(8'h30, 1, 1, 2'd1, 1, 0, 1);
        step(8'h40, 1, 0, 2'd2, 1, 0, 0);
        step(8'h50, 1, 0, 2'd3, 1, 0, 0);
        push(8'h30, 8'h40, 8'h50, 8'h60);
        step(8'h60, 1, 0, 2'd0, 1, 1, 0);

        // Frame with din_valid gaps; frame_sync on an invalid cycle is ignored
        step(8'hA5, 1, 1, 2'd1, 1, 0, 0);
        step(8'hEE, 0, 1, 2'd1, 1, 0, 0);
        step(8'hB6, 1, 0, 2'd2, 1, 0, 0);
        step(8'hC7, 1, 0, 2'd3, 1, 0, 0);
        step(8'hEE, 0, 0, 2'd3, 1, 0, 0);
        push(8'hA5, 8'hB6, 8'hC7, 8'hD8);
        step(8'hD8, 1, 0, 2'd0, 1, 1, 0);

        // Sync on the slot-3 word realigns instead of completing
        step(8'hE1, 1, 1, 2'd1, 1, 0, 0);
        step(8'hE2, 1, 0, 2'd2, 1, 0, 0);
        step(8'hE3, 1, 0, 2'd3, 1, 0, 0);
        step(8'hE4, 1, 1, 2'd1, 1, 0, 1);
        step(8'hF2, 1, 0, 2'd2, 1, 0, 0);
        step(8'hF3, 1, 0, 2'd3, 1, 0, 0);
        push(8'hE4, 8'hF2, 8'hF3, 8'hF4);
        step(8'hF4, 1, 0, 2'd0, 1, 1, 0);

        // Asynchronous reset mid-frame, between clock edges
        step(8'h9A, 1, 1, 2'd1, 1, 0, 0);
        step(8'h9B, 1, 0, 2'd2, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        last_frame = 32'h0;
        #1 rst_n = 1'b1;
        step(8'h33, 1, 0, 2'd0, 0, 0, 0);
        step(8'hC1, 1, 1, 2'd1, 1, 0, 0);
        step(8'hC2, 1, 0, 2'd2, 1, 0, 0);
        step(8'hC3, 1, 0, 2'd3, 1, 0, 0);
        push(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        step(8'hC4, 1, 0, 2'd0, 1, 1, 0);
        step(8'h00, 0, 0, 2'd0, 1, 0, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
